// File: rtl/cpu_types_pkg.sv
// Shared CPU types and constants: word type, PC step, and the
// saturating-counter encodings used by the branch predictor.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Sequential fetch step: one 32-bit instruction.
    localparam word_t PC_STEP = 32'd4;

    // Two-bit saturating-counter encodings; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr2_e;

    // Weakly-taken value for a counter of the given width (MSB set, rest clear).
    function automatic int unsigned ctr_weak_taken(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/update bundle between the fetch/resolve pipeline (master)
// and the branch predictor (slave).
interface branch_predictor_if;
    import cpu_types_pkg::*;

    word_t lookup_pc;
    logic  pred_hit;
    logic  pred_taken;
    word_t pred_npc;
    logic  upd_valid;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  upd_jump;
    logic  upd_mispredict;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_jump, upd_mispredict,
        input  pred_hit, pred_taken, pred_npc
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_jump, upd_mispredict,
        output pred_hit, pred_taken, pred_npc
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for one saturating counter: load has priority,
// then increment/decrement clamped at all-ones and zero.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] nxt
);
    localparam logic [WIDTH-1:0] CTR_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CTR_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CTR_ONE  = WIDTH'(32'd1);

    // Select load, clamped step, or hold.
    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (inc && (cur != CTR_MAX)) begin
            nxt = cur + CTR_ONE;
        end else if (dec && (cur != CTR_ZERO)) begin
            nxt = cur - CTR_ONE;
        end else begin
            nxt = cur;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational and sees pre-update contents; updates and
// flushes land on the rising CLK edge.
// Optional feature: define BP_STATS_EN to build the lookup/mispredict
// statistics counters; otherwise both stat outputs are tied to zero.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                en,
    input  logic                flush_all,
    branch_predictor_if.slave   bp,
    output word_t               stat_lookups,
    output word_t               stat_mispredicts
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_taken(CTR_BITS) - 32'd1);

    logic                valid_r [ENTRIES];
    logic [TAG_W-1:0]    tag_r   [ENTRIES];
    word_t               tgt_r   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r   [ENTRIES];

    logic [IDX-1:0]      lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic [IDX-1:0]      up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    logic                up_hit_s;
    logic                wr_s;
    logic                ctr_load_s;
    logic [CTR_BITS-1:0] ctr_load_val_s;
    logic [CTR_BITS-1:0] ctr_nxt_s;
    logic                unused_s;

    assign lk_idx_s = bp.lookup_pc[IDX+1:2];
    assign lk_tag_s = bp.lookup_pc[31:IDX+2];
    assign up_idx_s = bp.upd_pc[IDX+1:2];
    assign up_tag_s = bp.upd_pc[31:IDX+2];
    assign unused_s = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0], bp.upd_mispredict};

    // Combinational lookup: hit, direction and next PC (wraps mod 2^32).
    always_comb begin
        bp.pred_hit   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        bp.pred_taken = bp.pred_hit && ctr_r[lk_idx_s][CTR_BITS-1];
        if (bp.pred_taken) begin
            bp.pred_npc = tgt_r[lk_idx_s];
        end else begin
            bp.pred_npc = bp.lookup_pc + PC_STEP;
        end
    end

    // Update decode: write on a tag hit or on a taken miss (allocation);
    // jumps and allocations load the counter instead of stepping it.
    always_comb begin
        up_hit_s       = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        wr_s           = en && bp.upd_valid && !flush_all && (up_hit_s || bp.upd_taken);
        ctr_load_s     = !up_hit_s || bp.upd_jump;
        if (bp.upd_jump) begin
            ctr_load_val_s = CTR_MAX;
        end else begin
            ctr_load_val_s = CTR_WT;
        end
    end

    sat_counter #(.WIDTH(CTR_BITS)) u_sat_counter (
        .cur      (ctr_r[up_idx_s]),
        .inc      (bp.upd_taken),
        .dec      (!bp.upd_taken),
        .load     (ctr_load_s),
        .load_val (ctr_load_val_s),
        .nxt      (ctr_nxt_s)
    );

    // Table state: reset, whole-table invalidate, or single-entry write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= '0;
                tgt_r[i]   <= 32'd0;
                ctr_r[i]   <= CTR_WNT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_s) begin
            valid_r[up_idx_s] <= 1'b1;
            tag_r[up_idx_s]   <= up_tag_s;
            tgt_r[up_idx_s]   <= bp.upd_target;
            ctr_r[up_idx_s]   <= ctr_nxt_s;
        end
    end

`ifdef BP_STATS_EN
    word_t stat_lookups_r;
    word_t stat_mispredicts_r;

    // Saturating statistics; unaffected by flush_all.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups_r     <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (en && (stat_lookups_r != 32'hFFFF_FFFF)) begin
                stat_lookups_r <= stat_lookups_r + 32'd1;
            end
            if (en && bp.upd_valid && bp.upd_mispredict &&
                (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_lookups     = stat_lookups_r;
    assign stat_mispredicts = stat_mispredicts_r;
`else
    assign stat_lookups     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CTR_BITS=2).
module tb_branch_predictor;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    logic  en;
    logic  flush_all;
    word_t stat_lookups;
    word_t stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .en               (en),
        .flush_all        (flush_all),
        .bp               (bp_if.slave),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one update for a single edge, then drop upd_valid.
    task automatic do_upd(input word_t pc, input logic taken, input word_t tgt, input logic jump);
        en                  = 1'b1;
        bp_if.upd_valid     = 1'b1;
        bp_if.upd_pc        = pc;
        bp_if.upd_taken     = taken;
        bp_if.upd_target    = tgt;
        bp_if.upd_jump      = jump;
        @(posedge CLK); #1;
        bp_if.upd_valid     = 1'b0;
        bp_if.upd_jump      = 1'b0;
    endtask

    // Drive a lookup PC and check all three prediction outputs.
    task automatic look(input string tag, input word_t pc, input logic hit, input logic tkn, input word_t npc);
        bp_if.lookup_pc = pc;
        #1;
        check_val({tag, ".hit"},   {31'd0, bp_if.pred_hit},   {31'd0, hit});
        check_val({tag, ".taken"}, {31'd0, bp_if.pred_taken}, {31'd0, tkn});
        check_val({tag, ".npc"},   bp_if.pred_npc,            npc);
    endtask

    initial begin
        nRST                 = 1'b0;
        en                   = 1'b0;
        flush_all            = 1'b0;
        bp_if.lookup_pc      = 32'h100;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_pc         = 32'd0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_target     = 32'd0;
        bp_if.upd_jump       = 1'b0;
        bp_if.upd_mispredict = 1'b0;

        // Reset state
        #12;
        look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        check_val("rst.stat_lk", stat_lookups, 32'd0);
        check_val("rst.stat_mp", stat_mispredicts, 32'd0);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        // Allocation; same-cycle lookup sees pre-update contents
        en               = 1'b1;
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h100;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'h200;
        look("nobypass", 32'h100, 1'b0, 1'b0, 32'h104);
        @(posedge CLK); #1;
        bp_if.upd_valid  = 1'b0;
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        // Counter walks down: 2 -> 1 -> 0 -> 0 (saturates low)
        do_upd(32'h100, 1'b0, 32'h200, 1'b0);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 32'h200, 1'b0);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 32'h200, 1'b0);
        // 0 -> 1 shows it stayed at 0 (a wrap to 3 would predict taken)
        do_upd(32'h100, 1'b1, 32'h280, 1'b0);
        look("satlo", 32'h100, 1'b1, 1'b0, 32'h104);
        // 1 -> 2 with new target
        do_upd(32'h100, 1'b1, 32'h280, 1'b0);
        look("retgt", 32'h100, 1'b1, 1'b1, 32'h280);
        // 2 -> 3 -> 3, then one not-taken -> 2: still taken
        do_upd(32'h100, 1'b1, 32'h280, 1'b0);
        do_upd(32'h100, 1'b1, 32'h280, 1'b0);
        do_upd(32'h100, 1'b0, 32'h280, 1'b0);
        look("sathi", 32'h100, 1'b1, 1'b1, 32'h280);

        // Same index, different tag replaces the entry
        do_upd(32'h140, 1'b1, 32'h500, 1'b0);
        look("evict.old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("evict.new", 32'h140, 1'b1, 1'b1, 32'h500);

        // Not-taken miss does not allocate
        do_upd(32'h180, 1'b0, 32'h900, 1'b0);
        look("ntmiss", 32'h180, 1'b0, 1'b0, 32'h184);
        look("ntmiss.keep", 32'h140, 1'b1, 1'b1, 32'h500);

        // Jump allocates strongly taken: one not-taken leaves it taken
        do_upd(32'h204, 1'b1, 32'h700, 1'b1);
        do_upd(32'h204, 1'b0, 32'h700, 1'b0);
        look("jump", 32'h204, 1'b1, 1'b1, 32'h700);

        // en low blocks the update
        en               = 1'b0;
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h240;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'h600;
        @(posedge CLK); #1;
        bp_if.upd_valid  = 1'b0;
        look("en0", 32'h240, 1'b0, 1'b0, 32'h244);
        look("en0.keep", 32'h140, 1'b1, 1'b1, 32'h500);

        // Next-PC wraps modulo 2^32
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Flush beats a concurrent taken update
        flush_all = 1'b1;
        do_upd(32'h300, 1'b1, 32'hA00, 1'b0);
        flush_all = 1'b0;
        look("flush.upd", 32'h300, 1'b0, 1'b0, 32'h304);
        look("flush.old", 32'h204, 1'b0, 1'b0, 32'h208);

        // Reset in the middle of an update discards it
        en               = 1'b1;
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h400;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'hB00;
        @(negedge CLK) nRST = 1'b0;
        @(posedge CLK); #1;
        bp_if.upd_valid  = 1'b0;
        en               = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        look("rstmid", 32'h400, 1'b0, 1'b0, 32'h404);

        // Statistics: 10 enabled edges, 3 with a mispredict
        for (int i = 0; i < 10; i++) begin
            en                   = 1'b1;
            bp_if.upd_valid      = (i < 3);
            bp_if.upd_mispredict = (i < 3);
            bp_if.upd_pc         = 32'h500;
            bp_if.upd_taken      = 1'b0;
            @(posedge CLK); #1;
        end
        en                   = 1'b0;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        @(posedge CLK); #1;
`ifdef BP_STATS_EN
        check_val("stat_lk", stat_lookups, 32'd10);
        check_val("stat_mp", stat_mispredicts, 32'd3);
`else
        check_val("stat_lk", stat_lookups, 32'd0);
        check_val("stat_mp", stat_mispredicts, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
